// File: rtl/window_buffer_if.sv
// Command, pixel and window bus between controlUnit, the row caches and the window buffer.
// The slave modport is the window buffer itself; the master modport is the controlling side.
interface window_buffer_if #(
  parameter int DATA_W   = 8,
  parameter int WIN_COLS = 4,
  parameter int CNT_W    = $clog2(WIN_COLS + 1)
);
  logic                         clear;
  logic                         enable_WB;
  logic [2:0]                   mode_WB;
  logic [DATA_W-1:0]            sram_rdata;
  logic [DATA_W-1:0]            sdram_rdata;
  logic [4*WIN_COLS*DATA_W-1:0] window;
  logic                         stage_full;
  logic [CNT_W-1:0]             fill_count;
  logic                         window_valid;
  logic                         shift_err;

  modport master (
    output clear, enable_WB, mode_WB, sram_rdata, sdram_rdata,
    input  window, stage_full, fill_count, window_valid, shift_err
  );

  modport slave (
    input  clear, enable_WB, mode_WB, sram_rdata, sdram_rdata,
    output window, stage_full, fill_count, window_valid, shift_err
  );
endinterface

// File: rtl/window_buffer.sv
// 4-row sliding pixel window: a staging column is loaded slot by slot from SRAM/SDRAM,
// then shifted in as the newest column when all four slots are present.
module window_buffer #(
  parameter int DATA_W   = 8,
  parameter int WIN_COLS = 4,
  parameter int CNT_W    = $clog2(WIN_COLS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  window_buffer_if.slave    wb
);

  localparam logic [2:0] MODE_S1   = 3'd1;
  localparam logic [2:0] MODE_S2   = 3'd2;
  localparam logic [2:0] MODE_SD3  = 3'd3;
  localparam logic [2:0] MODE_SD4  = 3'd4;
  localparam logic [2:0] MODE_SHFT = 3'd5;

  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(WIN_COLS);

  logic [DATA_W-1:0] stage_q [4];
  logic [DATA_W-1:0] stage_d [4];
  logic [3:0]        stage_mask_q, stage_mask_d;
  logic [DATA_W-1:0] win_q [4][WIN_COLS];
  logic [DATA_W-1:0] win_d [4][WIN_COLS];
  logic [CNT_W-1:0]  fill_count_q, fill_count_d;
  logic              shift_err_q, shift_err_d;

  always_comb begin
    stage_d      = stage_q;
    stage_mask_d = stage_mask_q;
    win_d        = win_q;
    fill_count_d = fill_count_q;
    shift_err_d  = 1'b0;

    if (wb.clear) begin
      // Stage data may keep stale pixels; the cleared mask makes them unusable.
      stage_mask_d = 4'b0000;
      fill_count_d = '0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < WIN_COLS; c++) begin
          win_d[r][c] = '0;
        end
      end
    end else if (wb.enable_WB) begin
      case (wb.mode_WB)
        MODE_S1: begin
          stage_d[0]      = wb.sram_rdata;
          stage_mask_d[0] = 1'b1;
        end
        MODE_S2: begin
          stage_d[1]      = wb.sram_rdata;
          stage_mask_d[1] = 1'b1;
        end
        MODE_SD3: begin
          stage_d[2]      = wb.sdram_rdata;
          stage_mask_d[2] = 1'b1;
        end
        MODE_SD4: begin
          stage_d[3]      = wb.sdram_rdata;
          stage_mask_d[3] = 1'b1;
        end
        MODE_SHFT: begin
          if (&stage_mask_q) begin
            for (int r = 0; r < 4; r++) begin
              for (int c = 0; c < WIN_COLS - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
              end
              win_d[r][WIN_COLS-1] = stage_q[r];
            end
            stage_mask_d = 4'b0000;
            if (fill_count_q != FILL_MAX) begin
              fill_count_d = fill_count_q + CNT_W'(1);
            end
          end else begin
            shift_err_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 4; r++) begin
        stage_q[r] <= '0;
        for (int c = 0; c < WIN_COLS; c++) begin
          win_q[r][c] <= '0;
        end
      end
      stage_mask_q <= 4'b0000;
      fill_count_q <= '0;
      shift_err_q  <= 1'b0;
    end else begin
      stage_q      <= stage_d;
      win_q        <= win_d;
      stage_mask_q <= stage_mask_d;
      fill_count_q <= fill_count_d;
      shift_err_q  <= shift_err_d;
    end
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < WIN_COLS; c++) begin : g_col
      assign wb.window[(r*WIN_COLS+c)*DATA_W +: DATA_W] = win_q[r][c];
    end
  end

  assign wb.stage_full   = &stage_mask_q;
  assign wb.fill_count   = fill_count_q;
  assign wb.window_valid = (fill_count_q == FILL_MAX);
  assign wb.shift_err    = shift_err_q;

endmodule

// File: tb/tb_window_buffer.sv
// Scoreboard bench for window_buffer: the driver pushes reference-model predictions,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_window_buffer;

  localparam int DATA_W   = 8;
  localparam int WIN_COLS = 4;
  localparam int CNT_W    = $clog2(WIN_COLS + 1);
  localparam int WIN_W    = 4 * WIN_COLS * DATA_W;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] S1   = 3'd1;
  localparam logic [2:0] S2   = 3'd2;
  localparam logic [2:0] SD3  = 3'd3;
  localparam logic [2:0] SD4  = 3'd4;
  localparam logic [2:0] SHFT = 3'd5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_buffer_if #(.DATA_W(DATA_W), .WIN_COLS(WIN_COLS), .CNT_W(CNT_W)) bus ();

  window_buffer #(.DATA_W(DATA_W), .WIN_COLS(WIN_COLS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  typedef struct {
    string             tag;
    logic [WIN_W-1:0]  window;
    logic              stage_full;
    logic [CNT_W-1:0]  fill_count;
    logic              window_valid;
    logic              shift_err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the window is a queue of columns, oldest at the front.
  typedef logic [3:0][DATA_W-1:0] col_t;
  col_t              m_cols[$];
  logic [DATA_W-1:0] m_stage[4];
  bit                m_loaded[4];
  int                m_fill;
  bit                m_err;

  function automatic void modelZeroWindow();
    m_cols.delete();
    for (int c = 0; c < WIN_COLS; c++) m_cols.push_back('0);
  endfunction

  function automatic void modelStep(input bit r, input bit clr, input bit en,
                                    input logic [2:0] mode,
                                    input logic [DATA_W-1:0] sr,
                                    input logic [DATA_W-1:0] sd);
    col_t nc;
    bit   all;
    m_err = 0;
    if (r) begin
      modelZeroWindow();
      for (int i = 0; i < 4; i++) begin
        m_stage[i]  = '0;
        m_loaded[i] = 0;
      end
      m_fill = 0;
    end else if (clr) begin
      modelZeroWindow();
      for (int i = 0; i < 4; i++) m_loaded[i] = 0;
      m_fill = 0;
    end else if (en) begin
      if (mode >= S1 && mode <= SD4) begin
        int idx;
        idx = int'(mode) - 1;
        m_stage[idx]  = (idx < 2) ? sr : sd;
        m_loaded[idx] = 1;
      end else if (mode == SHFT) begin
        all = m_loaded[0] && m_loaded[1] && m_loaded[2] && m_loaded[3];
        if (all) begin
          for (int i = 0; i < 4; i++) nc[i] = m_stage[i];
          void'(m_cols.pop_front());
          m_cols.push_back(nc);
          for (int i = 0; i < 4; i++) m_loaded[i] = 0;
          if (m_fill < WIN_COLS) m_fill++;
        end else begin
          m_err = 1;
        end
      end
    end
  endfunction

  function automatic exp_t modelExpect(input string tag);
    exp_t e;
    e.tag = tag;
    e.window = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < WIN_COLS; c++)
        e.window[(r*WIN_COLS+c)*DATA_W +: DATA_W] = m_cols[c][r];
    e.stage_full   = m_loaded[0] && m_loaded[1] && m_loaded[2] && m_loaded[3];
    e.fill_count   = CNT_W'(m_fill);
    e.window_valid = (m_fill == WIN_COLS);
    e.shift_err    = m_err;
    return e;
  endfunction

  function automatic void compareField(input string tag, input string field,
                                       input logic [WIN_W-1:0] got,
                                       input logic [WIN_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s got=%0h expected=%0h", tag, field, got, exp);
    end
  endfunction

  task automatic checkOutput(input exp_t e);
    compareField(e.tag, "window",       bus.window,                 e.window);
    compareField(e.tag, "stage_full",   WIN_W'(bus.stage_full),     WIN_W'(e.stage_full));
    compareField(e.tag, "fill_count",   WIN_W'(bus.fill_count),     WIN_W'(e.fill_count));
    compareField(e.tag, "window_valid", WIN_W'(bus.window_valid),   WIN_W'(e.window_valid));
    compareField(e.tag, "shift_err",    WIN_W'(bus.shift_err),      WIN_W'(e.shift_err));
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
  end

  task automatic applyStimulus(input bit r, input bit clr, input bit en,
                               input logic [2:0] mode,
                               input logic [DATA_W-1:0] sr,
                               input logic [DATA_W-1:0] sd,
                               input string tag);
    rst             = r;
    bus.clear       = clr;
    bus.enable_WB   = en;
    bus.mode_WB     = mode;
    bus.sram_rdata  = sr;
    bus.sdram_rdata = sd;
    @(posedge clk);
    modelStep(r, clr, en, mode, sr, sd);
    sb_q.push_back(modelExpect(tag));
    @(negedge clk);
  endtask

  task automatic cmd(input logic [2:0] mode, input logic [DATA_W-1:0] sr,
                     input logic [DATA_W-1:0] sd, input string tag);
    applyStimulus(0, 0, 1, mode, sr, sd, tag);
  endtask

  task automatic loadColumn(input logic [DATA_W-1:0] base, input string tag);
    cmd(S1,  base + 8'd0, 8'hEE, tag);
    cmd(S2,  base + 8'd1, 8'hEE, tag);
    cmd(SD3, 8'hEE, base + 8'd2, tag);
    cmd(SD4, 8'hEE, base + 8'd3, tag);
  endtask

  initial begin
    rst             = 1'b1;
    bus.clear       = 1'b0;
    bus.enable_WB   = 1'b0;
    bus.mode_WB     = NOP;
    bus.sram_rdata  = '0;
    bus.sdram_rdata = '0;
    m_fill = 0;
    modelZeroWindow();
    @(negedge clk);

    for (int i = 0; i < 2; i++)
      applyStimulus(1, 0, 1, S1, DATA_W'($urandom), DATA_W'($urandom), "reset");

    cmd(S1,  8'h11, 8'h00, "single");
    cmd(S2,  8'h22, 8'h00, "single");
    cmd(SD3, 8'h00, 8'h33, "single");
    cmd(SD4, 8'h00, 8'h44, "single");
    cmd(SHFT, 8'h00, 8'h00, "single_shift");

    applyStimulus(0, 1, 0, NOP, 8'h00, 8'h00, "fill_clear");
    for (int k = 1; k <= 5; k++) begin
      loadColumn(DATA_W'(16 * k), "fill_load");
      cmd(SHFT, 8'h00, 8'h00, "fill_shift");
    end

    cmd(S1,  8'h61, 8'h00, "incomplete");
    cmd(S2,  8'h62, 8'h00, "incomplete");
    cmd(SD3, 8'h00, 8'h63, "incomplete");
    cmd(SHFT, 8'h00, 8'h00, "incomplete_shift");
    cmd(NOP,  8'h00, 8'h00, "incomplete_after");
    cmd(SD4, 8'h00, 8'h64, "incomplete");
    cmd(SHFT, 8'h00, 8'h00, "completed_shift");

    cmd(S1, 8'hAA, 8'h00, "overwrite");
    cmd(S1, 8'hBB, 8'h00, "overwrite");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, SHFT, 8'h5A, 8'hA5, "idle_hold");
    cmd(S2,  8'h72, 8'h00, "overwrite");
    cmd(SD3, 8'h00, 8'h73, "overwrite");
    cmd(SD4, 8'h00, 8'h74, "overwrite");
    cmd(SHFT, 8'h00, 8'h00, "overwrite_shift");

    applyStimulus(0, 1, 0, NOP, 8'h00, 8'h00, "midfill_clear0");
    for (int k = 0; k < 3; k++) begin
      loadColumn(DATA_W'(8'h80 + 8'h10 * k), "midfill_load");
      cmd(SHFT, 8'h00, 8'h00, "midfill_shift");
    end
    cmd(S1, 8'hC1, 8'h00, "midfill_load");
    cmd(S2, 8'hC2, 8'h00, "midfill_load");
    applyStimulus(0, 1, 1, SHFT, 8'h00, 8'h00, "midfill_clear");
    cmd(NOP, 8'h00, 8'h00, "midfill_after");

    for (int i = 0; i < 500; i++) begin
      bit       r, clr, en;
      logic [2:0] mode;
      r    = ($urandom_range(0, 99) == 0);
      clr  = ($urandom_range(0, 39) == 0);
      en   = ($urandom_range(0, 7) != 0);
      mode = ($urandom_range(0, 2) == 0) ? SHFT : 3'($urandom_range(0, 7));
      applyStimulus(r, clr, en, mode, DATA_W'($urandom), DATA_W'($urandom), "random");
    end

    bus.enable_WB = 1'b0;
    bus.clear     = 1'b0;
    rst           = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got=%0d pending expected=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_buffer.md
Name: window_buffer

Overview:
- Sliding pixel window sitting directly downstream of controlUnit. It is driven by enable_WB and mode_WB.
- Captures rows 1-2 from SRAM read data and rows 3-4 from SDRAM read data into a staging column.
- On a shift command, pushes the completed staging column into a 4-row x WIN_COLS window.
- Presents the full window to the filter datapath and flags when the window is fully populated.

Parameters:
- DATA_W, 8, pixel width in bits.
- WIN_COLS, 4, window columns; minimum 2.
- CNT_W, $clog2(WIN_COLS+1), width of the column fill counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  start of new image row; flushes fill state.
- enable_WB  input  1  command strobe from controlUnit; mode_WB is acted on only when high.
- mode_WB  input  3  0 NOP, 1 S1, 2 S2, 3 SD3, 4 SD4, 5 SHFT, 6-7 reserved (NOP).
- sram_rdata  input  DATA_W  pixel from SRAM row cache.
- sdram_rdata  input  DATA_W  pixel from SDRAM.
- window  output  4*WIN_COLS*DATA_W  pixel (r,c) at bits [(r*WIN_COLS+c)*DATA_W +: DATA_W]; c=0 is oldest column.
- stage_full  output  1  all four staging slots loaded (&stage_mask).
- fill_count  output  CNT_W  number of valid columns, saturates at WIN_COLS.
- window_valid  output  1  fill_count == WIN_COLS.
- shift_err  output  1  one-cycle pulse: SHFT issued with stage incomplete.

Behaviour:
- Reset (rst=1 at an edge):
  - window, stage[0..3], stage_mask, fill_count all 0.
  - window_valid=0, shift_err=0, stage_full=0.
  - Reset overrides every other input, including mid-load or mid-fill.
- Priority per edge: rst > clear > enable_WB command.
- clear=1:
  - stage_mask=0, fill_count=0, window_valid=0, window zeroed, shift_err=0.
  - stage data registers need not be zeroed.
  - Any concurrent command is ignored.
- enable_WB=0: all state held; shift_err=0.
- Load commands (enable_WB=1):
  - S1: stage[0]<=sram_rdata, stage_mask[0]<=1.
  - S2: stage[1]<=sram_rdata, stage_mask[1]<=1.
  - SD3: stage[2]<=sdram_rdata, stage_mask[2]<=1.
  - SD4: stage[3]<=sdram_rdata, stage_mask[3]<=1.
  - Reloading an already-set slot overwrites its data silently; mask stays 1.
- SHFT with stage_mask==4'b1111:
  - For each row r and c<WIN_COLS-1: window(r,c)<=window(r,c+1).
  - window(r,WIN_COLS-1)<=stage[r].
  - stage_mask<=0.
  - fill_count<=min(fill_count+1, WIN_COLS).
- SHFT with stage_mask!=4'b1111:
  - Window, mask and fill_count unchanged.
  - shift_err=1 for exactly that following cycle.
- NOP/reserved modes: no state change.
- Timing and latency:
  - All outputs are registered; one-cycle latency from command edge to visible result.
  - window_valid and stage_full are derived from registered state, so they are valid the cycle after the causing edge.
- Saturation: once fill_count==WIN_COLS, further valid SHFTs still slide the window; fill_count holds at WIN_COLS and window_valid stays 1.
- Only one command is accepted per cycle, so loads and shifts cannot collide. A load is never merged with a shift.

Test Plan:
- Reset: drive garbage data with enable_WB=1, mode=S1, rst=1 for 2 cycles -> window=0, fill_count=0, stage_full=0, window_valid=0, shift_err=0.
- Single column: S1 0x11, S2 0x22, SD3 0x33, SD4 0x44 -> stage_full=1. Then SHFT -> column 3 of rows 0-3 = 0x11/0x22/0x33/0x44; fill_count=1; stage_full=0.
- Fill and slide: push columns k=1..5 with pixel value 0x10*k+r. After the 4th SHFT, window_valid=1 and fill_count=4. After the 5th SHFT, column 0 holds k=2 data, fill_count=4, window_valid still 1.
- Incomplete shift: load S1, S2, SD3 only, then SHFT -> shift_err=1 for one cycle, window unchanged, fill_count unchanged. Then SD4 + SHFT -> shift succeeds.
- Hold and overwrite: S1 0xAA then S1 0xBB; idle 3 cycles with enable_WB=0 holding mode=SHFT; complete the rest of the stage; SHFT -> row 0 new column = 0xBB, and no shift occurred during the idle cycles.
- Clear mid-fill: after 3 shifts and 2 loads, assert clear together with enable_WB=1, mode=SHFT -> fill_count=0, stage_full=0, window=0, no shift, shift_err=0.
